// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: state encoding,
// default operand width and index-counter width helper.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 6;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_cmp_cell.sv
// Per-bit decision cell: flags a not-yet-decided differing bit and the ordering it implies.
// At the sign bit a set A bit means A is negative, so signed ordering inverts there.
module serial_cmp_cell (
  input  logic abit,
  input  logic bbit,
  input  logic is_msb,
  input  logic decided,
  output logic differ,
  output logic ltu_bit,
  output logic lt_bit
);

  always_comb begin
    differ  = (abit ^ bbit) & ~decided;
    ltu_bit = ~abit & bbit;
    lt_bit  = is_msb ? (abit & ~bbit) : (~abit & bbit);
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial lt/ltu/eq comparator, MSB-first scan with valid/ready on both sides.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing bit instead of after WIDTH bits.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             ltu,
  output logic             eq
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_MSB = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             lt_q, lt_d, ltu_q, ltu_d, eq_q, eq_d;
  logic             out_valid_q, out_valid_d;
  logic             differ, ltu_bit, lt_bit;

  serial_cmp_cell u_cell (
    .abit    (a_sh_q[WIDTH-1]),
    .bbit    (b_sh_q[WIDTH-1]),
    .is_msb  (cnt_q == CNT_MSB),
    .decided (decided_q),
    .differ  (differ),
    .ltu_bit (ltu_bit),
    .lt_bit  (lt_bit)
  );

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    cnt_d       = cnt_q;
    decided_d   = decided_q;
    lt_d        = lt_q;
    ltu_d       = ltu_q;
    eq_d        = eq_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d    = a;
          b_sh_d    = b;
          cnt_d     = CNT_MSB;
          decided_d = 1'b0;
          lt_d      = 1'b0;
          ltu_d     = 1'b0;
          eq_d      = 1'b0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d = {a_sh_q[WIDTH-2:0], 1'b0};
        b_sh_d = {b_sh_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        // Only the first differing bit writes the flags; later bits are masked by decided.
        if (differ) begin
          decided_d = 1'b1;
          lt_d      = lt_bit;
          ltu_d     = ltu_bit;
        end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (differ || (cnt_q == '0)) begin
`else
        if (cnt_q == '0) begin
`endif
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          eq_d        = ~(decided_q | differ);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      cnt_q       <= '0;
      decided_q   <= 1'b0;
      lt_q        <= 1'b0;
      ltu_q       <= 1'b0;
      eq_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      cnt_q       <= cnt_d;
      decided_q   <= decided_d;
      lt_q        <= lt_d;
      ltu_q       <= ltu_d;
      eq_q        <= eq_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign lt        = lt_q;
  assign ltu       = ltu_q;
  assign eq        = eq_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator (WIDTH=6): directed table, handshake and
// reset corners, then exhaustive and random sweeps against an arithmetic reference.
module tb_serial_magnitude_comparator;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, lt, ltu, eq;

  int n_cmp = 0;
  int n_bad = 0;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt        (lt),
    .ltu       (ltu),
    .eq        (eq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         lt;
    logic         ltu;
    logic         eq;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: ordering from plain signed/unsigned arithmetic; latency from first differing bit.
  function automatic int ref_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    logic [W-1:0] x;
    x = av ^ bv;
    for (int i = 0; i < W; i++)
      if (x[W-1-i]) return i + 1;
    return W;
`else
    return (av == bv) ? W : W;
`endif
  endfunction

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    int n;
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    if (!out_valid) chk("result_timeout", 0, 1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic elt, input logic eltu, input logic eeq);
    int lat;
    out_ready = 1'b1;
    start_op(av, bv);
    wait_result(lat);
    chk({tag, "_lt"}, int'(lt), int'(elt));
    chk({tag, "_ltu"}, int'(ltu), int'(eltu));
    chk({tag, "_eq"}, int'(eq), int'(eeq));
    chk({tag, "_lat"}, lat, ref_lat(av, bv));
    @(posedge clk);
    #1;
    chk({tag, "_vld_drop"}, int'(out_valid), 0);
  endtask

  task automatic run_model(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
    run_op(tag, av, bv, $signed(av) < $signed(bv), av < bv, av == bv);
  endtask

  vec_t tbl[8];
  int   lat;

  initial begin
    tbl[0] = '{6'd5,  6'd9,  1'b1, 1'b1, 1'b0};
    tbl[1] = '{6'h20, 6'h01, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{6'h01, 6'h3F, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{6'h2A, 6'h2A, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{6'h3F, 6'h1F, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{6'h00, 6'h3F, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{6'h1F, 6'h20, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{6'h3F, 6'h3E, 1'b0, 1'b0, 1'b0};

    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_flags", int'({lt, ltu, eq}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].lt, tbl[i].ltu, tbl[i].eq);

    // Consumer stalls three cycles in DONE; a competing request must be ignored.
    out_ready = 1'b0;
    start_op(6'd5, 6'd9);
    wait_result(lat);
    chk("stall_lat", lat, ref_lat(6'd5, 6'd9));
    a = 6'h3F;
    b = 6'h00;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_vld", int'(out_valid), 1);
      chk("stall_flags", int'({lt, ltu, eq}), 3'b110);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release", int'(out_valid), 0);
    chk("stall_idle", int'(in_ready), 1);
    run_model("after_stall", 6'h3F, 6'h00);

    // Asynchronous reset in the third RUN cycle, checked before any further clock edge.
    start_op(6'd3, 6'd12);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_flags", int'({lt, ltu, eq}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 6'd7, 6'd7, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < (1 << (2 * W)); i++)
      run_model("sweep", W'(i >> W), W'(i));

    for (int i = 0; i < 300; i++)
      run_model("rand", W'($urandom), W'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
